// File: rtl/icap_mb_pkg.sv
// Shared constants, state encoding and IPROG word lookup for the ICAP MultiBoot controller.
package icap_mb_pkg;

    localparam int unsigned ICAP_W = 16;
    localparam int unsigned ADDR_W = 24;
    localparam int unsigned WIDX_W = 5;
    localparam int unsigned DLY_W  = 8;

    localparam logic [ICAP_W-1:0] ICAP_DUMMY = 16'hFFFF;
    localparam logic [ICAP_W-1:0] SYNC_H     = 16'hAA99;
    localparam logic [ICAP_W-1:0] SYNC_L     = 16'h5566;
    localparam logic [ICAP_W-1:0] GEN1_WR    = 16'h3261;
    localparam logic [ICAP_W-1:0] GEN2_WR    = 16'h3281;
    localparam logic [ICAP_W-1:0] CMD_WR     = 16'h30A1;
    localparam logic [ICAP_W-1:0] CMD_IPROG  = 16'h000E;
    localparam logic [ICAP_W-1:0] ICAP_NOOP  = 16'h2000;

    // Index of the first NOOP word; everything from here on is NOOP
    localparam int unsigned FIRST_NOOP_IDX = 9;

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_IDLE = 2'd1,
        ST_SEQ  = 2'd2,
        ST_DONE = 2'd3
    } mb_state_e;

    typedef struct packed {
        logic              ce_n;
        logic              wr_n;
        logic [ICAP_W-1:0] din;
    } icap_bus_t;

    // Pre-swap IPROG word for a given sequence index
    function automatic logic [ICAP_W-1:0] seq_word(
        input logic [WIDX_W-1:0] idx,
        input logic [ADDR_W-1:0] addr,
        input logic [7:0]        opcode
    );
        logic [ICAP_W-1:0] w;
        case (idx)
            WIDX_W'(0): w = ICAP_DUMMY;
            WIDX_W'(1): w = SYNC_H;
            WIDX_W'(2): w = SYNC_L;
            WIDX_W'(3): w = GEN1_WR;
            WIDX_W'(4): w = addr[15:0];
            WIDX_W'(5): w = GEN2_WR;
            WIDX_W'(6): w = {opcode, addr[23:16]};
            WIDX_W'(7): w = CMD_WR;
            WIDX_W'(8): w = CMD_IPROG;
            default:    w = ICAP_NOOP;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/icap_byte_swap.sv
// Per-byte bit reversal mapping logical configuration words onto the ICAP I-bus bit order.
module icap_byte_swap
    import icap_mb_pkg::*;
(
    input  logic [ICAP_W-1:0] i_word,
    output logic [ICAP_W-1:0] o_word_c
);

    always_comb begin
        o_word_c = '0;
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 8; i++) begin
                o_word_c[b*8 + i] = i_word[b*8 + 7 - i];
            end
        end
    end

endmodule

// File: rtl/icap_multiboot_ctrl.sv
// Spartan-6 ICAP MultiBoot controller: accepts a slot request, computes the warm-boot
// address and streams the IPROG sequence into ICAP with hold-off and BUSY stall.
module icap_multiboot_ctrl
    import icap_mb_pkg::*;
#(
    parameter int unsigned       NUM_SLOTS   = 8,
    parameter int unsigned       SLOT_W      = 3,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 24'h000000,
    parameter logic [ADDR_W-1:0] SLOT_STRIDE = 24'h054000,
    parameter logic [7:0]        SPI_OPCODE  = 8'h03,
    parameter int unsigned       NOOP_COUNT  = 4,
    parameter int unsigned       START_DELAY = 15
) (
    input  logic              i_fastclk,
    input  logic              i_rst,
    input  logic              i_req,
    input  logic [SLOT_W-1:0] i_slot,
    output logic              o_ack,
    output logic              o_err,
    output logic              o_busy,
    input  logic              i_icap_busy,
    output logic              o_icap_ce_n,
    output logic              o_icap_wr_n,
    output logic [ICAP_W-1:0] o_icap_din
);

    localparam logic [WIDX_W-1:0] LAST_IDX  = WIDX_W'(FIRST_NOOP_IDX + NOOP_COUNT - 1);
    localparam logic [DLY_W-1:0]  HOLD_LAST = DLY_W'(START_DELAY - 1);

    mb_state_e         r_state;
    logic [DLY_W-1:0]  r_dly;
    logic [WIDX_W-1:0] r_widx;
    logic [ADDR_W-1:0] r_addr;
    logic              r_ack;
    logic              r_err;
    logic              r_busy;
    icap_bus_t         r_icap;

    mb_state_e         w_state_d;
    logic [DLY_W-1:0]  w_dly_d;
    logic [WIDX_W-1:0] w_widx_d;
    logic [ADDR_W-1:0] w_addr_d;
    logic              w_ack_d;
    logic              w_err_d;
    logic              w_busy_d;
    logic              w_ce_n_d;
    logic              w_wr_n_d;
    logic [ICAP_W-1:0] w_word;
    logic [ICAP_W-1:0] w_word_sw;
    icap_bus_t         w_bus_d;
    logic              w_slot_ok;
    logic [ADDR_W-1:0] w_addr_calc;

    assign w_slot_ok   = (32'(i_slot) < NUM_SLOTS);
    // Constant-stride multiply-add, wraps modulo 2^24
    assign w_addr_calc = BASE_ADDR + ADDR_W'(i_slot) * SLOT_STRIDE;

    always_comb begin
        w_state_d = r_state;
        w_dly_d   = r_dly;
        w_widx_d  = r_widx;
        w_addr_d  = r_addr;
        w_ack_d   = 1'b0;
        w_err_d   = 1'b0;
        w_ce_n_d  = 1'b1;
        w_wr_n_d  = 1'b1;
        w_word    = ICAP_DUMMY;

        case (r_state)
            ST_HOLD: begin
                if (r_dly == HOLD_LAST) begin
                    w_state_d = ST_IDLE;
                end else begin
                    w_dly_d = r_dly + DLY_W'(1);
                end
            end
            ST_IDLE: begin
                if (i_req) begin
                    w_ack_d = 1'b1;
                    if (w_slot_ok) begin
                        w_addr_d  = w_addr_calc;
                        w_widx_d  = '0;
                        w_state_d = ST_SEQ;
                    end else begin
                        w_err_d = 1'b1;
                    end
                end
            end
            ST_SEQ: begin
                w_word   = seq_word(r_widx, r_addr, SPI_OPCODE);
                w_ce_n_d = 1'b0;
                w_wr_n_d = 1'b0;
                // ICAP BUSY freezes the index so the same word is re-presented
                if (!i_icap_busy) begin
                    if (r_widx == LAST_IDX) begin
                        w_state_d = ST_DONE;
                    end else begin
                        w_widx_d = r_widx + WIDX_W'(1);
                    end
                end
            end
            ST_DONE: begin
                w_state_d = ST_DONE;
            end
            default: begin
                w_state_d = ST_HOLD;
            end
        endcase

        w_busy_d = (w_state_d != ST_IDLE);
    end

    icap_byte_swap u_swap (
        .i_word   (w_word),
        .o_word_c (w_word_sw)
    );

    assign w_bus_d = '{ce_n: w_ce_n_d, wr_n: w_wr_n_d, din: w_word_sw};

    always_ff @(posedge i_fastclk) begin
        if (i_rst) begin
            r_state <= ST_HOLD;
            r_dly   <= '0;
            r_widx  <= '0;
            r_addr  <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b1;
            r_icap  <= '{ce_n: 1'b1, wr_n: 1'b1, din: ICAP_DUMMY};
        end else begin
            r_state <= w_state_d;
            r_dly   <= w_dly_d;
            r_widx  <= w_widx_d;
            r_addr  <= w_addr_d;
            r_ack   <= w_ack_d;
            r_err   <= w_err_d;
            r_busy  <= w_busy_d;
            r_icap  <= w_bus_d;
        end
    end

    assign o_ack       = r_ack;
    assign o_err       = r_err;
    assign o_busy      = r_busy;
    assign o_icap_ce_n = r_icap.ce_n;
    assign o_icap_wr_n = r_icap.wr_n;
    assign o_icap_din  = r_icap.din;

endmodule

// File: tb/tb_icap_multiboot_ctrl.sv
// Scoreboard bench for icap_multiboot_ctrl: expected ICAP words and ack/err events are
// queued at stimulus time and checked by an independent monitor.
module tb_icap_multiboot_ctrl;

    localparam int unsigned START_DELAY = 15;
    localparam int unsigned SEQ_LEN     = 13;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [3:0]  slot;
    logic        icap_busy;
    logic        ack;
    logic        err;
    logic        busy;
    logic        ce_n;
    logic        wr_n;
    logic [15:0] din;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] exp_words[$];
    logic        exp_ack[$];

    always #5 clk = ~clk;

    icap_multiboot_ctrl #(
        .NUM_SLOTS   (8),
        .SLOT_W      (4),
        .BASE_ADDR   (24'h000000),
        .SLOT_STRIDE (24'h054000),
        .SPI_OPCODE  (8'h03),
        .NOOP_COUNT  (4),
        .START_DELAY (START_DELAY)
    ) dut (
        .i_fastclk   (clk),
        .i_rst       (rst),
        .i_req       (req),
        .i_slot      (slot),
        .o_ack       (ack),
        .o_err       (err),
        .o_busy      (busy),
        .i_icap_busy (icap_busy),
        .o_icap_ce_n (ce_n),
        .o_icap_wr_n (wr_n),
        .o_icap_din  (din)
    );

    function automatic logic [15:0] rev_bytes(input logic [15:0] v);
        logic [15:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i]     = v[7 - i];
            r[8 + i] = v[15 - i];
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, expv);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: actual=event required=no event", name);
    endtask

    // Expected pre-swap sequence; extra copies of 5566 model a BUSY stall there
    task automatic push_seq(input logic [15:0] g1, input logic [15:0] g2, input int extra_5566);
        exp_words.push_back(16'hFFFF);
        exp_words.push_back(16'hAA99);
        exp_words.push_back(16'h5566);
        repeat (extra_5566) exp_words.push_back(16'h5566);
        exp_words.push_back(16'h3261);
        exp_words.push_back(g1);
        exp_words.push_back(16'h3281);
        exp_words.push_back(g2);
        exp_words.push_back(16'h30A1);
        exp_words.push_back(16'h000E);
        repeat (4) exp_words.push_back(16'h2000);
    endtask

    // Monitor: pops and compares whenever the DUT drives an ICAP word or an ack
    initial begin
        logic [15:0] w;
        logic        e;
        forever begin
            @(negedge clk);
            if (ce_n === 1'b0) begin
                if (exp_words.size() == 0) begin
                    fail_now("unexpected_icap_word");
                end else begin
                    w = exp_words.pop_front();
                    check("icap_din", 32'(din), 32'(rev_bytes(w)));
                    check("icap_wr_n", 32'(wr_n), 32'd0);
                end
            end
            if (ack === 1'b1) begin
                if (exp_ack.size() == 0) begin
                    fail_now("unexpected_ack");
                end else begin
                    e = exp_ack.pop_front();
                    check("err_with_ack", 32'(err), 32'(e));
                end
            end
            if (err === 1'b1 && ack !== 1'b1) fail_now("err_without_ack");
        end
    end

    task automatic check_reset_vals();
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_ce_n", 32'(ce_n), 32'd1);
        check("rst_wr_n", 32'(wr_n), 32'd1);
        check("rst_din", 32'(din), 32'hFFFF);
    endtask

    task automatic do_reset();
        int c;
        @(negedge clk);
        rst = 1'b1;
        req = 1'b0;
        icap_busy = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals();
        rst = 1'b0;
        c = 0;
        while (busy !== 1'b0 && c < 40) begin
            @(negedge clk);
            c++;
        end
        check("holdoff_len", 32'(c), 32'(START_DELAY));
    endtask

    task automatic issue(input logic [3:0] s, input logic e);
        @(negedge clk);
        req  = 1'b1;
        slot = s;
        exp_ack.push_back(e);
        @(negedge clk);
        req = 1'b0;
        check("ack_pulse", 32'(ack), 32'd1);
        check("busy_after_req", 32'(busy), e ? 32'd0 : 32'd1);
    endtask

    // Follows the sequence on the pins; optional BUSY stall and mid-sequence reset
    task automatic run_seq(input int stall_at, input int stall_len, input int rst_at, output int active);
        bit seen;
        bit stalled;
        int left;
        seen = 0;
        stalled = 0;
        left = 0;
        active = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (ce_n === 1'b0) begin
                active++;
                seen = 1;
            end else if (seen) begin
                return;
            end
            if (left > 0) begin
                left--;
                if (left == 0) icap_busy = 1'b0;
            end
            if (ce_n === 1'b0 && active == 2 && !stalled)
                check("aa99_pin_order", 32'(din), 32'h5599);
            if (ce_n === 1'b0 && active == stall_at && stall_len > 0 && !stalled) begin
                icap_busy = 1'b1;
                left = stall_len;
            end
            if (ce_n === 1'b0 && active == 2) stalled = 1;
            if (ce_n === 1'b0 && active == rst_at) begin
                rst = 1'b1;
                return;
            end
        end
        fail_now("sequence_timeout");
    endtask

    task automatic check_done();
        check("done_busy", 32'(busy), 32'd1);
        check("done_ce_n", 32'(ce_n), 32'd1);
        check("done_wr_n", 32'(wr_n), 32'd1);
        check("done_din", 32'(din), 32'hFFFF);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int act;
        bit got;

        rst = 1'b1;
        req = 1'b1;
        slot = 4'd0;
        icap_busy = 1'b0;

        // Request held through reset and hold-off; slot 0
        repeat (3) @(negedge clk);
        check_reset_vals();
        exp_ack.push_back(1'b0);
        push_seq(16'h0000, 16'h0300, 0);
        rst = 1'b0;
        cyc = 0;
        got = 0;
        while (cyc < 40 && !got) begin
            @(negedge clk);
            cyc++;
            if (cyc == START_DELAY) check("busy_low_first_idle", 32'(busy), 32'd0);
            if (ack === 1'b1) got = 1;
        end
        check("ack_latency", 32'(cyc), 32'(START_DELAY + 1));
        check("busy_on_accept", 32'(busy), 32'd1);
        run_seq(0, 0, 0, act);
        check("seq_len_slot0", 32'(act), 32'(SEQ_LEN));
        check_done();
        repeat (10) @(negedge clk);
        req = 1'b0;
        check("queue_empty_t1", 32'(exp_words.size()), 32'd0);

        // Slot 2 -> 0A8000
        do_reset();
        push_seq(16'h8000, 16'h030A, 0);
        issue(4'd2, 1'b0);
        run_seq(0, 0, 0, act);
        check("seq_len_slot2", 32'(act), 32'(SEQ_LEN));
        check_done();

        // Out-of-range slots rejected, then slot 5 -> 1A4000
        do_reset();
        issue(4'd9, 1'b1);
        repeat (3) begin
            @(negedge clk);
            check("reject_ce_n", 32'(ce_n), 32'd1);
            check("reject_busy", 32'(busy), 32'd0);
        end
        issue(4'd8, 1'b1);
        push_seq(16'h4000, 16'h031A, 0);
        issue(4'd5, 1'b0);
        run_seq(0, 0, 0, act);
        check("seq_len_slot5", 32'(act), 32'(SEQ_LEN));

        // BUSY stall of 3 cycles on 5566; slot 7 -> 24C000
        do_reset();
        push_seq(16'hC000, 16'h0324, 3);
        issue(4'd7, 1'b0);
        run_seq(2, 3, 0, act);
        check("seq_len_stall", 32'(act), 32'(SEQ_LEN + 3));
        check_done();

        // Reset while 30A1 is on the pins; rerun from scratch
        do_reset();
        push_seq(16'h0000, 16'h0300, 0);
        issue(4'd0, 1'b0);
        run_seq(0, 0, 8, act);
        @(posedge clk);
        #1;
        check("midrst_ce_n", 32'(ce_n), 32'd1);
        check("midrst_wr_n", 32'(wr_n), 32'd1);
        check("midrst_din", 32'(din), 32'hFFFF);
        check("midrst_busy", 32'(busy), 32'd1);
        check("midrst_pending", 32'(exp_words.size()), 32'd5);
        exp_words.delete();
        do_reset();
        push_seq(16'h0000, 16'h0300, 0);
        issue(4'd0, 1'b0);
        run_seq(0, 0, 0, act);
        check("seq_len_rerun", 32'(act), 32'(SEQ_LEN));
        check_done();

        repeat (5) @(negedge clk);
        check("final_words_empty", 32'(exp_words.size()), 32'd0);
        check("final_acks_empty", 32'(exp_ack.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
